// File: rtl/tpu_pkg.sv
// Shared types and derived-size helpers for the TPU sequencer and its sub-blocks.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tpu_state_e;

  function automatic int matrix_bits(input int array_size);
    return $clog2(2 * array_size - 1);
  endfunction

  function automatic int read_len(input int array_size, input int batch_size,
                                  input int queue_size);
    return array_size * batch_size + queue_size - 1;
  endfunction

  function automatic int last_cnt(input int result_lat, input int array_size,
                                  input int batch_size);
    return result_lat + (batch_size + 1) * array_size - 2;
  endfunction

endpackage

// File: rtl/tpu_out_addr_gen.sv
// Per-batch output write decode: turns the run counter into that batch's
// diagonal write enable and address.
module tpu_out_addr_gen
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE  = 16,
  parameter int CNT_W       = 7,
  parameter int OFFSET      = 4,
  parameter int MATRIX_BITS = matrix_bits(ARRAY_SIZE)
) (
  input  logic                   active_i,
  input  logic [CNT_W-1:0]       cnt_i,
  output logic                   wen_o,
  output logic [MATRIX_BITS-1:0] addr_o
);

  // Two spare bits: one for the sign, one so the subtraction cannot wrap.
  localparam int DW = CNT_W + 2;
  localparam logic signed [DW-1:0] OFS    = DW'(OFFSET);
  localparam logic signed [DW-1:0] LAST_D = DW'(2 * ARRAY_SIZE - 2);

  logic signed [DW-1:0] diag;

  always_comb begin
    diag   = $signed({2'b00, cnt_i}) - OFS;
    wen_o  = active_i && !diag[DW-1] && (diag <= LAST_D);
    addr_o = wen_o ? diag[MATRIX_BITS-1:0] : '0;
  end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// TPU run sequencer: one start pulse streams operand reads, enables the array
// and writes each batch's result diagonals, then raises tpu_finish.
module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE      = 16,
  parameter int BATCH_SIZE      = 3,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int QUEUE_SIZE      = 4,
  parameter int RESULT_LAT      = 4,
  localparam int MATRIX_BITS    = matrix_bits(ARRAY_SIZE)
) (
  input  logic                              clk,
  input  logic                              srstn,
  input  logic                              tpu_start,
  output logic                              tpu_finish,
  output logic                              sram_ren,
  output logic [SRAM_ADDR_WIDTH-1:0]        sram_raddr,
  output logic                              array_en,
  output logic [BATCH_SIZE-1:0]             out_wen,
  output logic [BATCH_SIZE*MATRIX_BITS-1:0] out_waddr,
  output logic                              busy
);

  localparam int READ_LEN = read_len(ARRAY_SIZE, BATCH_SIZE, QUEUE_SIZE);
  localparam int LAST_CNT = last_cnt(RESULT_LAT, ARRAY_SIZE, BATCH_SIZE);
  localparam int CNT_W    = $clog2(LAST_CNT + 1);

  tpu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                              run_d;
  logic                              ren_d;
  logic [SRAM_ADDR_WIDTH-1:0]        raddr_d;
  logic [BATCH_SIZE-1:0]             wen_d;
  logic [BATCH_SIZE*MATRIX_BITS-1:0] waddr_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every variable; no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (tpu_start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(LAST_CNT)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state so that cycle k after start shows cnt=k.
  always_comb begin
    run_d   = (state_d == RUN);
    ren_d   = run_d && (cnt_d < CNT_W'(READ_LEN));
    raddr_d = ren_d ? SRAM_ADDR_WIDTH'(cnt_d) : '0;
  end

  for (genvar b = 0; b < BATCH_SIZE; b++) begin : g_batch
    tpu_out_addr_gen #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .CNT_W      (CNT_W),
      .OFFSET     (RESULT_LAT + b * ARRAY_SIZE)
    ) u_addr_gen (
      .active_i (run_d),
      .cnt_i    (cnt_d),
      .wen_o    (wen_d[b]),
      .addr_o   (waddr_d[b*MATRIX_BITS +: MATRIX_BITS])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tpu_finish <= 1'b0;
      sram_ren   <= 1'b0;
      sram_raddr <= '0;
      array_en   <= 1'b0;
      out_wen    <= '0;
      out_waddr  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tpu_finish <= (state_d == DONE);
      sram_ren   <= ren_d;
      sram_raddr <= raddr_d;
      array_en   <= run_d;
      out_wen    <= wen_d;
      out_waddr  <= waddr_d;
      busy       <= run_d;
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl at default parameters (N=16, B=3).
module tb_tpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        srstn = 1'b1;
  logic        tpu_start = 1'b0;
  logic        tpu_finish;
  logic        sram_ren;
  logic [9:0]  sram_raddr;
  logic        array_en;
  logic [2:0]  out_wen;
  logic [14:0] out_waddr;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tpu_seq_ctrl #(
    .ARRAY_SIZE      (16),
    .BATCH_SIZE      (3),
    .SRAM_ADDR_WIDTH (10),
    .QUEUE_SIZE      (4),
    .RESULT_LAT      (4)
  ) dut (
    .clk        (clk),
    .srstn      (srstn),
    .tpu_start  (tpu_start),
    .tpu_finish (tpu_finish),
    .sram_ren   (sram_ren),
    .sram_raddr (sram_raddr),
    .array_en   (array_en),
    .out_wen    (out_wen),
    .out_waddr  (out_waddr),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_finish);
    check({tag, " finish"},   32'(tpu_finish), 32'(exp_finish));
    check({tag, " busy"},     32'(busy),       32'd0);
    check({tag, " ren"},      32'(sram_ren),   32'd0);
    check({tag, " raddr"},    32'(sram_raddr), 32'd0);
    check({tag, " array_en"}, 32'(array_en),   32'd0);
    check({tag, " wen"},      32'(out_wen),    32'd0);
    check({tag, " waddr"},    32'(out_waddr),  32'd0);
  endtask

  // Expected outputs in cycle k: reads 0..50, batch b writes d=k-4-16b in 0..30.
  task automatic check_run_cycle(input string tag, input int k);
    logic [2:0]  ew;
    logic [14:0] ea;
    string       t;
    ew = '0;
    ea = '0;
    for (int b = 0; b < 3; b++) begin
      int d;
      d = k - 4 - 16 * b;
      if (d >= 0 && d <= 30) begin
        ew[b]         = 1'b1;
        ea[b*5 +: 5]  = 5'(d);
      end
    end
    t = $sformatf("%s k=%0d", tag, k);
    check({t, " busy"},     32'(busy),       32'd1);
    check({t, " array_en"}, 32'(array_en),   32'd1);
    check({t, " finish"},   32'(tpu_finish), 32'd0);
    check({t, " ren"},      32'(sram_ren),   (k <= 50) ? 32'd1 : 32'd0);
    check({t, " raddr"},    32'(sram_raddr), (k <= 50) ? 32'(k) : 32'd0);
    check({t, " wen"},      32'(out_wen),    32'(ew));
    check({t, " waddr"},    32'(out_waddr),  32'(ea));
  endtask

  // Leaves the bench in cycle 0 of a new run.
  task automatic pulse_start();
    tpu_start = 1'b1;
    tick();
    tpu_start = 1'b0;
  endtask

  // Checks cycles 0..66 of a run and the finish in cycle 67; optionally
  // re-pulses start during cycle restart_at to show it is ignored.
  task automatic run_full(input string tag, input int restart_at);
    for (int k = 0; k <= 66; k++) begin
      check_run_cycle(tag, k);
      if (k == restart_at) tpu_start = 1'b1;
      tick();
      tpu_start = 1'b0;
    end
    check_idle({tag, " k=67"}, 1'b1);
  endtask

  initial begin
    // Reset and idle with no start.
    #2 srstn = 1'b0;
    #1 check_idle("in_reset", 1'b0);
    tick();
    tick();
    srstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle($sformatf("no_start c=%0d", i), 1'b0);
    end

    // First full run, then finish must hold in DONE.
    pulse_start();
    run_full("run1", -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("done_hold c=%0d", i), 1'b1);
    end

    // Start from DONE clears finish at once; a start in cycle 10 is ignored.
    pulse_start();
    run_full("run2", 10);

    // Reset mid-run during cycle 40.
    tick();
    pulse_start();
    for (int k = 0; k <= 40; k++) begin
      check_run_cycle("run3", k);
      if (k < 40) tick();
    end
    #2 srstn = 1'b0;
    #1 check_idle("midrun_reset", 1'b0);
    @(posedge clk);
    #1 check_idle("midrun_reset_held", 1'b0);
    #2 srstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("post_reset c=%0d", i), 1'b0);
    end

    pulse_start();
    run_full("run4", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_seq_ctrl.md
# tpu_seq_ctrl

Sequencer for the TPU top-level. A single `tpu_start` pulse makes it stream the skewed operand words out of the weight and input SRAM queues. It enables the output-stationary systolic array while data is in flight and writes each batch's result diagonals into that batch's output SRAM. It then raises `tpu_finish`. It sits inside `tpu_top_wrap`, between the start/finish handshake and the SRAM/array datapath.

## Interface
Parameters:
- `ARRAY_SIZE`, 16: systolic array dimension N.
- `BATCH_SIZE`, 3: number of matrix batches B per run.
- `SRAM_ADDR_WIDTH`, 10: operand SRAM address width.
- `QUEUE_SIZE`, 4: bytes per SRAM word. The skew across a queue adds `QUEUE_SIZE-1` extra read words.
- `RESULT_LAT`, 4: cycles from the read of operand address k to the completion of diagonal d=0 of batch 0 at the array output.
- Derived: `MATRIX_BITS = $clog2(2*ARRAY_SIZE-1)`, `READ_LEN = ARRAY_SIZE*BATCH_SIZE+QUEUE_SIZE-1`, `LAST_CNT = RESULT_LAT+(BATCH_SIZE+1)*ARRAY_SIZE-2`.

Ports:
- `clk`  in  1  clock, rising edge.
- `srstn`  in  1  asynchronous, active-low reset.
- `tpu_start`  in  1  one-cycle start pulse.
- `tpu_finish`  out  1  level; high once the run completes, held until the next accepted start.
- `sram_ren`  out  1  read enable, shared by all weight and input SRAM queues.
- `sram_raddr`  out  SRAM_ADDR_WIDTH  read address, shared by all queues.
- `array_en`  out  1  systolic array shift/accumulate enable.
- `out_wen`  out  BATCH_SIZE  per-batch output SRAM write enable.
- `out_waddr`  out  BATCH_SIZE*MATRIX_BITS  packed per-batch write address (diagonal index). Batch b occupies bits `[b*MATRIX_BITS +: MATRIX_BITS]`.
- `busy`  out  1  high while in RUN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- IDLE → RUN on `tpu_start`=1, with `cnt`=0.
- RUN: `cnt` increments every cycle. RUN → DONE when `cnt`==`LAST_CNT`.
- DONE → RUN on `tpu_start`, which clears `tpu_finish` and sets `cnt`=0.
- `tpu_start` during RUN is ignored. It neither restarts nor extends the run.
- Reads: `sram_ren`=1 and `sram_raddr`=`cnt` for `cnt` in 0..READ_LEN-1. Otherwise `sram_ren`=0 and `sram_raddr`=0.
- `array_en`=1 for the whole RUN state, `cnt` 0..LAST_CNT.
- Writes for each batch b: let d = `cnt` − RESULT_LAT − b*ARRAY_SIZE. `out_wen[b]`=1 with address d iff 0 ≤ d ≤ 2*ARRAY_SIZE−2; otherwise the enable and address are 0. Compute d in a signed or widened width so that negative values never alias.
- Batch write windows overlap, because the window length 2N−1 is longer than the spacing N. At most two `out_wen` bits are high together, and they always target different SRAMs. No arbitration is needed.
- Reset mid-run: all outputs drop asynchronously to their reset values and the FSM returns to IDLE. SRAM contents are untouched.

## Timing
- Reset values: `tpu_finish`=0, `sram_ren`=0, `sram_raddr`=0, `array_en`=0, `out_wen`=0, `out_waddr`=0, `busy`=0.
- All outputs are registered and driven from the registered FSM state and `cnt`.
- "Cycle k" means the k-th cycle after the edge that samples `tpu_start` (k=0 is the first).
- In cycle k the outputs reflect `cnt`=k.
- Defaults (N=16, B=3):
  - Reads occur in cycles 0..50.
  - Batch 0 writes in cycles 4..34, batch 1 in 20..50, batch 2 in 36..66.
  - `tpu_finish` rises in cycle 67, and `busy` falls in the same cycle.
- Start-to-finish latency is LAST_CNT+1 cycles (67 at defaults).

## Structure
- Shared package `tpu_pkg` holds:
  - the state enum `tpu_state_e` (IDLE, RUN, DONE);
  - the derived localparam functions for `MATRIX_BITS`, `READ_LEN` and `LAST_CNT`.
- Sub-module `tpu_out_addr_gen` is instantiated once per batch through a generate loop.
  - Inputs: `cnt` and the batch offset parameter.
  - Outputs: that batch's `out_wen` bit and its address slice.
- `cnt` width is `$clog2(LAST_CNT+1)`.

## Test plan
- Reset, then no start for 20 cycles → every output stays 0 and `busy`=0.
- Single start pulse → `sram_raddr` steps 0..50 in cycles 0..50, and `sram_ren` is 0 in cycle 51.
- Same run, check the writes:
  - batch 0: `out_wen[0]` only in cycles 4..34 with addresses 0..30;
  - batch 1: `out_wen[1]` in cycles 20..50;
  - batch 2: `out_wen[2]` in cycles 36..66;
  - overlap: cycle 30 has bits 0 and 1 set with addresses 26 and 10.
- Start pulse re-asserted in cycle 10 → ignored; `tpu_finish` still rises in cycle 67.
- `srstn` pulsed low during cycle 40 → outputs go to 0 immediately; a later start runs the full 67-cycle sequence from `cnt`=0.
- Start while in DONE → `tpu_finish` is 0 in the next cycle, and a second identical 67-cycle run follows.
